// File: rtl/fnd_pkg.sv
// Shared types and constants for the fnd_scan_driver display path.
// The optional leading-zero blanking is selected in the top with FND_LZ_BLANK_EN.
package fnd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    localparam int DEFAULT_DIGIT_TICKS = 100000;
    localparam int DEFAULT_BLANK_TICKS = 16;

    localparam logic [13:0] BCD_MAX = 14'd9999;

    // Active-low {g,f,e,d,c,b,a}; the decimal point is added by the top.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 14-bit binary to four BCD nibbles in 14 shift cycles.
// bcd_out is only meaningful while done is high.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] bin_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd_out
);

    conv_state_t state, state_next;
    logic [29:0] shreg, shreg_next;
    logic [3:0]  cnt, cnt_next;

    // One double-dabble iteration on {bcd[15:0], bin[13:0]}.
    function automatic logic [29:0] dabble_step(input logic [29:0] v);
        logic [29:0] a;
        a = v;
        for (int n = 0; n < 4; n++) begin
            if (a[14 + 4*n +: 4] >= 4'd5)
                a[14 + 4*n +: 4] = a[14 + 4*n +: 4] + 4'd3;
        end
        return {a[28:0], 1'b0};
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    shreg_next = {16'h0000, bin_in};
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shreg_next = dabble_step(shreg);
                cnt_next   = cnt + 4'd1;
                if (cnt == 4'd13)
                    state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign bcd_out = shreg[29:14];

endmodule

// File: rtl/fnd_scan_driver.sv
// Four-digit common-anode 7-segment scan driver with BCD conversion and anti-ghost blanking.
// Define FND_LZ_BLANK_EN to blank leading zeros on digits 3..1.
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int DIGIT_TICKS = DEFAULT_DIGIT_TICKS,
    parameter int BLANK_TICKS = DEFAULT_BLANK_TICKS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] seg_data,
    input  logic        dp_en,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int TICK_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_TICKS - 1);
    localparam logic [TICK_W-1:0] BLANK_END = TICK_W'(BLANK_TICKS);

    logic [13:0]       data_q;
    logic [13:0]       last_val;
    logic [15:0]       bcd_q;
    logic [TICK_W-1:0] tick_cnt;
    logic [1:0]        dig_idx;

    logic        conv_start;
    logic        conv_busy;
    logic        conv_done;
    logic [15:0] conv_bcd;

    logic [3:0]  nibble;
    logic        lz_blank;
    logic [6:0]  glyph;
    logic        dp_n;

    // A request is only accepted while the converter is idle, so bcd_q never mixes values.
    assign conv_start = (data_q != last_val);

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .start   (conv_start),
        .bin_in  (data_q),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q   <= '0;
            last_val <= '0;
            bcd_q    <= '0;
        end else begin
            data_q <= (seg_data > BCD_MAX) ? BCD_MAX : seg_data;
            if (conv_start && !conv_busy)
                last_val <= data_q;
            if (conv_done)
                bcd_q <= conv_bcd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            dig_idx  <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            dig_idx  <= dig_idx + 2'd1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_comb begin
        lz_blank = 1'b0;
`ifdef FND_LZ_BLANK_EN
        case (dig_idx)
            2'd3:    lz_blank = (bcd_q[15:12] == 4'd0);
            2'd2:    lz_blank = (bcd_q[15:8]  == 8'd0);
            2'd1:    lz_blank = (bcd_q[15:4]  == 12'd0);
            default: lz_blank = 1'b0;
        endcase
`endif
    end

    assign nibble = bcd_q[{dig_idx, 2'b00} +: 4];
    assign glyph  = lz_blank ? SEG_BLANK : seg7_decode(nibble);
    assign dp_n   = ~((dig_idx == 2'd2) && dp_en);

    // Anodes stay off for the first BLANK_TICKS of every slot to hide segment switching.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'hF;
            seg <= 8'hFF;
        end else begin
            an  <= (tick_cnt < BLANK_END) ? 4'hF : ~(4'b0001 << dig_idx);
            seg <= {dp_n, glyph};
        end
    end

endmodule

// File: doc/fnd_scan_driver.md
# fnd_scan_driver

Four-digit, time-multiplexed 7-segment display driver that consumes the 14-bit `seg_data` value produced by the watch/stopwatch control path and drives the board's common-anode display. It converts the binary value to BCD with a sequential double-dabble engine, then scans the four digits with anti-ghosting blanking. It sits between the mode/command controller and the top-level `an`/`seg` pins.

## Interface
- `DIGIT_TICKS`, default 100000: clocks each digit is selected (1 ms at 100 MHz).
- `BLANK_TICKS`, default 16: clocks at the start of each digit slot during which all anodes are off. Must be < `DIGIT_TICKS`.
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-high.
- `seg_data`  in  14  binary display value, intended range 0..9999.
- `dp_en`  in  1  lights the decimal point on digit 2 (HH.MM / SS.CC separator).
- `an`  out  4  anode selects, active-low; `an[0]` is the rightmost digit (ones).
- `seg`  out  8  segments, active-low; `{dp,g,f,e,d,c,b,a}`.

## Operation
- **Input stage**
  - `seg_data` is registered into `data_q` every cycle.
  - Values above 9999 saturate to 9999.
- **Converter FSM** with states IDLE, SHIFT and DONE:
  - **IDLE:** if `data_q != last_val`, load `last_val <= data_q`, load the shift register {16-bit BCD = 0, 14-bit binary}, set the iteration count to 0 and go to SHIFT. Otherwise stay in IDLE.
  - **SHIFT:** each cycle, add 3 to every BCD nibble that is ≥5, then shift left by 1. After the 14th shift, go to DONE.
  - **DONE:** copy the BCD result to `bcd_q` (4 nibbles) and return to IDLE.
  - If `seg_data` changes during SHIFT or DONE, the conversion in flight completes with its old value. IDLE then detects the mismatch and restarts. `bcd_q` never holds a partial or mixed result.
- **Scan**
  - `tick_cnt` counts 0..`DIGIT_TICKS`-1.
  - On wrap, `dig_idx` advances 0→1→2→3→0.
  - While `tick_cnt < BLANK_TICKS`, `an` = 4'hF. Otherwise `an` = ~(1 << `dig_idx`).
- **Segment decode** (active-low `{g..a}`, shown with dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Blank = FF.
- **Decimal point:** `seg[7]` = 0 only when `dig_idx`==2 and `dp_en`=1. `dp_en` takes effect even on a blanked digit.
- **Reset values:**
  - `an`=4'hF, `seg`=8'hFF.
  - `data_q`=0, `last_val`=0, `bcd_q`=0.
  - `tick_cnt`=0, `dig_idx`=0, FSM=IDLE.
  - Reset mid-conversion abandons the conversion, and the outputs blank immediately (asynchronous).

## Timing
- `seg_data` change sampled at edge N+1 (into `data_q`).
- IDLE start at edge N+2.
- SHIFT runs on edges N+3..N+16.
- `bcd_q` valid after edge N+17, i.e. 17-cycle latency when the FSM is idle.
- Worst case, when the change arrives just after IDLE was left: latency ≤ 17 + 16 = 33 cycles.
- `an` and `seg` are registered. They reflect the new `dig_idx`/`bcd_q` one cycle after the change.
- Digit slot = `DIGIT_TICKS` cycles; frame = 4×`DIGIT_TICKS` cycles.
- The first visible digit after reset is digit 0, at `tick_cnt`=`BLANK_TICKS`+1 edges after reset release.

## Configuration
- `FND_LZ_BLANK_EN` defined: leading-zero blanking.
  - Digits 3..1 show FF while they and all higher digits are 0.
  - Digit 0 is never blanked.
  - Example: 0042 shows as blank, blank, 4, 2.
- `FND_LZ_BLANK_EN` undefined: all four digits are always decoded. 0042 shows as 0, 0, 4, 2.

## Structure
- **Shared package `fnd_pkg`:**
  - converter state enum (IDLE/SHIFT/DONE)
  - 7-seg pattern constants for 0–9 and blank
  - `BCD_MAX` = 9999
  - default tick constants
- **Sub-module `bin2bcd_seq`:** the double-dabble FSM, with `start`/`bin_in`/`busy`/`done`/`bcd_out`.
- **Top module:** input saturation, change detection, scan counters and decode.

## Test plan
Bench parameters: `DIGIT_TICKS`=8, `BLANK_TICKS`=2.
1. **Reset:** assert `reset` → `an`=F, `seg`=FF immediately. Release with `seg_data`=0 → digit 0 shows C0. With the macro, digits 1–3 show FF; without it, C0.
2. **Conversion and scan:** `seg_data`=1234 → `bcd_q`=1234 exactly 17 cycles later. Over one frame, observe `an`=E/D/B/7 with `seg`=99/B0/A4/F9.
3. **Saturation:** `seg_data`=16383 → all digits show 90 (9999).
4. **Mid-conversion change:** `seg_data` 1234→5678 on the 5th SHIFT cycle → `bcd_q` becomes 1234, then 5678 within 33 cycles. No other value ever appears.
5. **Decimal point:** `dp_en`=1 with `seg_data`=1234 → digit 2 `seg`=24. All other digits keep bit7=1. During the blank slot, `an`=F.
6. **Asynchronous reset mid-frame:** assert `reset` at `dig_idx`=2 with `tick_cnt`=5 → `an`=F and `seg`=FF without waiting for a clock edge. After release, the scan restarts at digit 0.
